// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the Fetch stage: widths, reset PC, NOP
// encoding, fetch FSM states and a word-alignment helper.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_t;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory request/response bundle. The fetch controller drives
// the request side (master); the memory answers on the slave side.
interface fetch_controller_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// IF/ID output register backed by a one-entry skid. A response that arrives
// while Decode is stalled parks in the skid and is promoted when the output
// is consumed. A flush empties both entries.
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic            stall,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            valid,
  output logic            skid_valid
);

  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            consume;

  assign consume = valid && !stall;

  // Output/skid update: flush beats load, load beats a plain consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= 1'b0;
      skid_valid  <= 1'b0;
      instruction <= '0;
      pc          <= '0;
      next_pc     <= '0;
      skid_instr  <= '0;
      skid_pc     <= '0;
    end else if (flush) begin
      valid      <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load) begin
      if (!valid || !stall) begin
        instruction <= load_instr;
        pc          <= load_pc;
        next_pc     <= load_pc + 32'd4;
        valid       <= 1'b1;
      end else begin
        skid_instr <= load_instr;
        skid_pc    <= load_pc;
        skid_valid <= 1'b1;
      end
    end else if (consume) begin
      if (skid_valid) begin
        instruction <= skid_instr;
        pc          <= skid_pc;
        next_pc     <= skid_pc + 32'd4;
        skid_valid  <= 1'b0;
      end else begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// RV32 Fetch-stage sequencer: one outstanding instruction-memory request,
// redirect handling with a DRAIN state for stale responses, and a skid
// buffer that absorbs Decode stalls.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pc_select_execute,
  input  logic [XLEN-1:0]           pc_target_execute,
  input  logic                      stall_fetch,
  fetch_controller_if.master        imem,
  output logic [XLEN-1:0]           instruction_fetch,
  output logic [XLEN-1:0]           pc_fetch,
  output logic [XLEN-1:0]           next_pc_fetch,
  output logic                      valid_fetch
);
  import riscv_pkg::*;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] fpc_next;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] pend_pc_next;
  logic [XLEN-1:0] target;
  logic            skid_valid;
  logic            ack;
  logic            load;

  assign target         = word_align(pc_target_execute);
  assign imem.imem_addr = word_align(fpc);
  assign ack            = imem.imem_req && imem.imem_ack;
  assign load           = ack && (state == RUN) && !pc_select_execute;

  // Request while draining a stale access, or in RUN whenever the skid has room.
  always_comb begin
    imem.imem_req = 1'b0;
    if (!rst) begin
      imem.imem_req = (state == DRAIN) || !skid_valid;
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      fpc     <= RESET_PC;
      pend_pc <= '0;
    end else begin
      state   <= state_next;
      fpc     <= fpc_next;
      pend_pc <= pend_pc_next;
    end
  end

  // Next-state and PC sequencing; a redirect outranks everything else.
  always_comb begin
    state_next   = state;
    fpc_next     = fpc;
    pend_pc_next = pend_pc;
    case (state)
      RUN: begin
        if (pc_select_execute) begin
          if (imem.imem_req && !imem.imem_ack) begin
            state_next   = DRAIN;
            pend_pc_next = target;
          end else begin
            fpc_next = target;
          end
        end else if (ack) begin
          fpc_next = fpc + 32'd4;
        end
      end
      DRAIN: begin
        if (ack) begin
          state_next = RUN;
          fpc_next   = pc_select_execute ? target : pend_pc;
        end else if (pc_select_execute) begin
          pend_pc_next = target;
        end
      end
      default: state_next = RUN;
    endcase
  end

  fetch_skid_buffer u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush       (pc_select_execute),
    .load        (load),
    .load_instr  (imem.imem_rdata),
    .load_pc     (fpc),
    .stall       (stall_fetch),
    .instruction (instruction_fetch),
    .pc          (pc_fetch),
    .next_pc     (next_pc_fetch),
    .valid       (valid_fetch),
    .skid_valid  (skid_valid)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios followed by random traffic,
// all compared each cycle against a queue-based model of the fetch stream.
module tb_fetch_controller;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] SALT     = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_select_execute;
  logic [31:0] pc_target_execute;
  logic        stall_fetch;
  logic [31:0] instruction_fetch;
  logic [31:0] pc_fetch;
  logic [31:0] next_pc_fetch;
  logic        valid_fetch;

  int n_vec = 0;
  int n_err = 0;

  entry_t      q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_target;
  logic        m_pending;

  fetch_controller_if mem_if ();

  fetch_controller #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_select_execute (pc_select_execute),
    .pc_target_execute (pc_target_execute),
    .stall_fetch       (stall_fetch),
    .imem              (mem_if),
    .instruction_fetch (instruction_fetch),
    .pc_fetch          (pc_fetch),
    .next_pc_fetch     (next_pc_fetch),
    .valid_fetch       (valid_fetch)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare against the model, then advance the model.
  task automatic applyStimulus(input logic r, input logic redir, input logic [31:0] tgt,
                               input logic stl, input logic ak);
    logic   exp_req;
    logic   consume;
    entry_t e;
    @(negedge clk);
    rst               = r;
    pc_select_execute = redir;
    pc_target_execute = tgt;
    stall_fetch       = stl;
    mem_if.imem_ack   = ak;
    mem_if.imem_rdata = ak ? (mem_if.imem_addr ^ SALT) : $urandom;
    #1;
    exp_req = !r && (q.size() < 2);
    checkOutput("imem_req", {31'd0, mem_if.imem_req}, {31'd0, exp_req});
    if (exp_req) checkOutput("imem_addr", mem_if.imem_addr, m_fpc);
    checkOutput("valid_fetch", {31'd0, valid_fetch}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      checkOutput("pc_fetch", pc_fetch, q[0].pc);
      checkOutput("next_pc_fetch", next_pc_fetch, q[0].pc + 32'd4);
      checkOutput("instruction_fetch", instruction_fetch, q[0].instr);
    end
    @(posedge clk);
    if (r) begin
      m_fpc     = RESET_PC;
      m_pending = 1'b0;
      q.delete();
    end else begin
      consume = (q.size() > 0) && !stl;
      if (redir) begin
        q.delete();
        if (exp_req && !ak) begin
          m_pending = 1'b1;
          m_target  = {tgt[31:2], 2'b00};
        end else begin
          m_pending = 1'b0;
          m_fpc     = {tgt[31:2], 2'b00};
        end
      end else if (exp_req && ak) begin
        if (m_pending) begin
          m_pending = 1'b0;
          m_fpc     = m_target;
        end else begin
          if (consume) q.delete(0);
          e.instr = m_fpc ^ SALT;
          e.pc    = m_fpc;
          q.push_back(e);
          m_fpc = m_fpc + 32'd4;
        end
      end else if (consume) begin
        q.delete(0);
      end
    end
  endtask

  // Directed scenarios, then random traffic, then the summary.
  initial begin
    rst               = 1'b1;
    pc_select_execute = 1'b0;
    pc_target_execute = '0;
    stall_fetch       = 1'b0;
    mem_if.imem_ack   = 1'b0;
    mem_if.imem_rdata = '0;
    m_fpc             = RESET_PC;
    m_target          = '0;
    m_pending         = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_valid", {31'd0, valid_fetch}, 32'd0);
    checkOutput("rst_pc", pc_fetch, 32'd0);
    checkOutput("rst_next_pc", next_pc_fetch, 32'd0);
    checkOutput("rst_instr", instruction_fetch, 32'd0);
    checkOutput("rst_addr", mem_if.imem_addr, RESET_PC);

    // Zero-wait stream from reset.
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    checkOutput("first_valid", {31'd0, valid_fetch}, 32'd1);
    checkOutput("first_pc", pc_fetch, 32'd0);
    checkOutput("first_next_pc", next_pc_fetch, 32'd4);
    checkOutput("first_instr", instruction_fetch, 32'hA5A5_0000);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    checkOutput("stream_pc8", pc_fetch, 32'h8);

    // Stall with pc 8 on the output: 0xC lands in the skid.
    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    checkOutput("unstall_pc", pc_fetch, 32'hC);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Redirect while a request waits on slow memory.
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    checkOutput("redir_pc", pc_fetch, 32'h100);
    checkOutput("redir_next_pc", next_pc_fetch, 32'h104);

    // Redirect together with an ack, a stall and a full skid.
    repeat (2) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h203, 1'b1, 1'b1);
    #2;
    checkOutput("simul_addr", mem_if.imem_addr, 32'h200);
    checkOutput("simul_valid", {31'd0, valid_fetch}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    checkOutput("wrap_pc", pc_fetch, 32'hFFFF_FFFC);
    checkOutput("wrap_next_pc", next_pc_fetch, 32'd0);
    checkOutput("wrap_addr", mem_if.imem_addr, 32'd0);

    // Reset while draining a redirect.
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    checkOutput("drain_rst_addr", mem_if.imem_addr, RESET_PC);
    checkOutput("drain_rst_valid", {31'd0, valid_fetch}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    checkOutput("drain_rst_pc", pc_fetch, RESET_PC);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 99) < 8,
                    $urandom,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
